hilo_div_sequencer: RTL

// - Multi-cycle sequencer for the Execute-stage HI/LO unit: runs DIV/DIVU (and MULT/MULTU if

---
 rtl/hilo_div_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/hilo_div_sequencer.sv
// Iterative HI/LO engine: 1-bit/cycle restoring DIV/DIVU, owns the HI/LO registers.
// Define HILO_MULT_EN to add shift-add MULT/MULTU; otherwise op_sel 10/11 are accepted as NOPs.
module hilo_div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [1:0]      op_sel,
    input  logic [XLEN-1:0] rs,
    input  logic [XLEN-1:0] rt,
    input  logic            flush,
    input  logic            mthi_we,
    input  logic            mtlo_we,
    input  logic [XLEN-1:0] wdata,
    input  logic            mf_req,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic            stall,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic              accept, launch;
    logic              is_signed, rs_neg, rt_neg;
    logic signed [XLEN-1:0] rs_s, rt_s;
    logic [XLEN-1:0]   rs_mag, rt_mag;
    logic              neg_q, neg_r, div_zero;
    logic [XLEN-1:0]   dvsr;
    logic [XLEN:0]     rem, rem_step;
    logic [XLEN+1:0]   rem_sh, diff;
    logic [XLEN-1:0]   quo, quo_step;
    logic [XLEN-1:0]   res_hi, res_lo;
`ifdef HILO_MULT_EN
    logic              mult_op;
    logic [XLEN:0]     acc;
    logic [2*XLEN-1:0] prod;
`endif

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + XLEN'(1)) : v;
    endfunction

`ifdef HILO_MULT_EN
    function automatic logic [2*XLEN-1:0] negate_wide(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? (~v + (2*XLEN)'(1)) : v;
    endfunction
`endif

    assign ready  = (state == IDLE);
    assign busy   = (state == CALC) || (state == FIX);
    assign stall  = busy & (mf_req | start | mthi_we | mtlo_we);
    assign accept = start & ready & ~flush;
`ifdef HILO_MULT_EN
    assign launch = accept;
`else
    // Multiply opcodes are swallowed without leaving IDLE.
    assign launch = accept & ~op_sel[1];
`endif

    assign is_signed = ~op_sel[0];
    assign rs_s      = rs;
    assign rt_s      = rt;
    assign rs_neg    = is_signed && (rs_s < 0);
    assign rt_neg    = is_signed && (rt_s < 0);
    assign rs_mag    = negate(rs, rs_neg);
    assign rt_mag    = negate(rt, rt_neg);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = CALC;
            CALC: begin
                if (flush)                          state_nxt = IDLE;
                else if (cnt == CNT_W'(XLEN - 1))   state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (launch)              cnt <= '0;
            else if (state == CALC)  cnt <= cnt + CNT_W'(1);
        end
    end

    // Iteration step: restoring divide by default, shift-add when multiplying.
    always_comb begin
        rem_sh = {rem, quo[XLEN-1]};
        diff   = rem_sh - {2'b00, dvsr};
        if (diff[XLEN+1]) begin
            rem_step = rem_sh[XLEN:0];
            quo_step = {quo[XLEN-2:0], 1'b0};
        end else begin
            rem_step = diff[XLEN:0];
            quo_step = {quo[XLEN-2:0], 1'b1};
        end
`ifdef HILO_MULT_EN
        acc = quo[0] ? (rem + {1'b0, dvsr}) : rem;
        if (mult_op) begin
            rem_step = {1'b0, acc[XLEN:1]};
            quo_step = {acc[0], quo[XLEN-1:1]};
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (launch) begin
            rem      <= '0;
            neg_q    <= rs_neg ^ rt_neg;
            neg_r    <= rs_neg;
            div_zero <= (rt == '0);
`ifdef HILO_MULT_EN
            mult_op  <= op_sel[1];
            dvsr     <= op_sel[1] ? rs_mag : rt_mag;
            quo      <= op_sel[1] ? rt_mag : rs_mag;
`else
            dvsr     <= rt_mag;
            quo      <= rs_mag;
`endif
        end else if (state == CALC) begin
            rem <= rem_step;
            quo <= quo_step;
        end
    end

    // A zero divisor leaves the raw dividend magnitude in rem, so sign fix restores rs.
    always_comb begin
        res_lo = div_zero ? '1 : negate(quo, neg_q);
        res_hi = negate(rem[XLEN-1:0], neg_r);
`ifdef HILO_MULT_EN
        prod = negate_wide({rem[XLEN-1:0], quo}, neg_q);
        if (mult_op) begin
            res_hi = prod[2*XLEN-1:XLEN];
            res_lo = prod[XLEN-1:0];
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == FIX && !flush) begin
                hi   <= res_hi;
                lo   <= res_lo;
                done <= 1'b1;
            end else if (state == IDLE) begin
                if (mthi_we) hi <= wdata;
                if (mtlo_we) lo <= wdata;
            end
        end
    end

endmodule
